// File: rtl/glb_psum_accum_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_glb_pkg : shared FSM encoding and default widths / saturation limits
// rev 1.0
// ---------------------------------------------------------------------------
package psum_glb_pkg;

  localparam int DEF_DATA_BITWIDTH = 16;
  localparam int DEF_ADDR_BITWIDTH = 10;

  localparam int SAT_MAX_DEF = (2 ** (DEF_DATA_BITWIDTH - 1)) - 1;
  localparam int SAT_MIN_DEF = -(2 ** (DEF_DATA_BITWIDTH - 1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/glb_psum_accum_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glb_psum_accum_if : pass control, router psum stream and host readback
// rev 1.0
// ---------------------------------------------------------------------------
interface glb_psum_accum_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
);
  logic                            start;
  logic                            first_pass;
  logic [ADDR_BITWIDTH:0]          psum_count;
  logic signed [DATA_BITWIDTH-1:0] psum_data_i;
  logic                            psum_enable_i;
  logic [ADDR_BITWIDTH-1:0]        psum_addr_i;
  logic                            rd_req;
  logic [ADDR_BITWIDTH-1:0]        rd_addr;
  logic signed [DATA_BITWIDTH-1:0] rd_data;
  logic                            rd_valid;
  logic                            busy;
  logic                            done;
  logic                            err;

  modport master (
    output start, first_pass, psum_count, psum_data_i, psum_enable_i, psum_addr_i,
    output rd_req, rd_addr,
    input  rd_data, rd_valid, busy, done, err
  );

  modport slave (
    input  start, first_pass, psum_count, psum_data_i, psum_enable_i, psum_addr_i,
    input  rd_req, rd_addr,
    output rd_data, rd_valid, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/glb_psum_accum_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psum_ram : 1R1W synchronous RAM, read-before-write, contents not reset
// rev 1.0
// ---------------------------------------------------------------------------
module psum_ram #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [ADDR_BITWIDTH-1:0]        waddr,
  input  logic signed [DATA_BITWIDTH-1:0] wdata,
  input  logic                            re,
  input  logic [ADDR_BITWIDTH-1:0]        raddr,
  output logic signed [DATA_BITWIDTH-1:0] rdata
);
  logic signed [DATA_BITWIDTH-1:0] mem [2**ADDR_BITWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule
`default_nettype wire

// File: rtl/glb_psum_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glb_psum_accum : psum GLB bank, overwrite/saturating-accumulate RMW pipeline
// rev 1.0
// ---------------------------------------------------------------------------
module glb_psum_accum
  import psum_glb_pkg::*;
#(
  parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH = DEF_ADDR_BITWIDTH
) (
  input  logic             clk,
  input  logic             reset,
  glb_psum_accum_if.slave  bus
);
  localparam logic signed [DATA_BITWIDTH-1:0] SAT_MAX = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
  localparam logic signed [DATA_BITWIDTH-1:0] SAT_MIN = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};

  state_t                          state, state_nx;
  logic                            fp_q;
  logic [ADDR_BITWIDTH:0]          cnt_q, count_q;
  logic                            v1, fwd;
  logic [ADDR_BITWIDTH-1:0]        a1;
  logic signed [DATA_BITWIDTH-1:0] d1, last_wr, ram_q, rd_hold, opnd, sum;
  logic signed [DATA_BITWIDTH:0]   sum_ext;
  logic                            accept, rd_svc, rd_valid_q;

  assign accept = bus.psum_enable_i && (state == ACCUM);
  assign rd_svc = bus.rd_req && (state == IDLE) && !v1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = (bus.psum_count == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && ((cnt_q + 1'b1) == count_q)) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1: an item directly behind a same-address item must take the
  // freshly computed value, since the RAM read happened before that write.
  always_comb begin
    opnd    = fwd ? last_wr : ram_q;
    sum_ext = {opnd[DATA_BITWIDTH-1], opnd} + {d1[DATA_BITWIDTH-1], d1};
    if (fp_q)
      sum = d1;
    else if (sum_ext[DATA_BITWIDTH] != sum_ext[DATA_BITWIDTH-1])
      sum = sum_ext[DATA_BITWIDTH] ? SAT_MIN : SAT_MAX;
    else
      sum = sum_ext[DATA_BITWIDTH-1:0];
  end

  psum_ram #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .ADDR_BITWIDTH (ADDR_BITWIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (v1 && reset),
    .waddr (a1),
    .wdata (sum),
    .re    (accept || rd_svc),
    .raddr ((state == ACCUM) ? bus.psum_addr_i : bus.rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      fp_q       <= 1'b0;
      cnt_q      <= '0;
      count_q    <= '0;
      v1         <= 1'b0;
      fwd        <= 1'b0;
      a1         <= '0;
      d1         <= '0;
      last_wr    <= '0;
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.busy <= (state_nx == ACCUM) || (state_nx == DRAIN);
      bus.done <= (state_nx == DONE);
      if ((state == IDLE) && bus.start) begin
        fp_q    <= bus.first_pass;
        count_q <= bus.psum_count;
        cnt_q   <= '0;
      end
      if (accept) begin
        cnt_q <= cnt_q + 1'b1;
        a1    <= bus.psum_addr_i;
        d1    <= bus.psum_data_i;
      end
      v1  <= accept;
      fwd <= accept && v1 && (a1 == bus.psum_addr_i);
      if (v1) last_wr <= sum;
      if (bus.psum_enable_i && (state != ACCUM)) bus.err <= 1'b1;
      rd_valid_q <= rd_svc;
      if (rd_valid_q) rd_hold <= ram_q;
    end
  end

  // The RAM output register moves with pipeline reads, so the last readback is held aside.
  assign bus.rd_data  = rd_valid_q ? ram_q : rd_hold;
  assign bus.rd_valid = rd_valid_q;

endmodule
`default_nettype wire

// File: doc/glb_psum_accum.md
Name: glb_psum_accum

Overview:
Psum global-buffer bank sitting directly downstream of the west psum router port. It consumes the router's serial psum stream (data, enable, GLB write address) and either overwrites or saturating-accumulates each value into a local psum RAM. A 2-stage read-modify-write pipeline has same-address forwarding. A pass FSM counts the expected psums, signals completion, and then opens a readback port to the host/DMA side.

Parameters:
DATA_BITWIDTH, 16, signed psum width
ADDR_BITWIDTH, 10, psum RAM address width; depth = 2**ADDR_BITWIDTH

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a pass; honoured only in IDLE
first_pass  in  1  sampled at start; 1 = overwrite, 0 = accumulate
psum_count  in  ADDR_BITWIDTH+1  number of psums expected this pass; sampled at start
psum_data_i  in  DATA_BITWIDTH  signed psum from router
psum_enable_i  in  1  psum_data_i/psum_addr_i valid this cycle
psum_addr_i  in  ADDR_BITWIDTH  RAM address for the psum
rd_req  in  1  host readback request
rd_addr  in  ADDR_BITWIDTH  readback address
rd_data  out  DATA_BITWIDTH  readback data
rd_valid  out  1  rd_data valid
busy  out  1  high in ACCUM and DRAIN
done  out  1  one-cycle pulse at pass completion
err  out  1  sticky; psum_enable_i seen outside ACCUM

Behaviour:
- Reset (reset==0 at a clock edge) clears FSM to IDLE, pipeline valid, fwd flag, counter, rd_data=0, rd_valid=0, busy=0, done=0, err=0. RAM contents are not cleared. Reset mid-pass drops any in-flight write.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
  - IDLE: on start, latch first_pass and psum_count, clear counter. Go to ACCUM, or to DONE directly if psum_count==0.
  - ACCUM: each psum_enable_i increments the counter. On the edge where counter+1==psum_count, go to DRAIN.
  - DRAIN: held exactly 1 cycle so stage-1 commits. Then go to DONE.
  - DONE: done=1 for this cycle. Then go to IDLE.
  - start outside IDLE is ignored.
- Pipeline, stage 0 (input edge): when psum_enable_i && state==ACCUM:
  - v1<=1, a1<=psum_addr_i, d1<=psum_data_i, rd_q<=mem[psum_addr_i] (synchronous read).
  - fwd<= v1 && (a1==psum_addr_i).
- Pipeline, stage 1 (cycle with v1=1):
  - opnd = fwd ? last_wr : rd_q.
  - sum = first_pass_q ? d1 : sat(opnd + d1).
  - At the edge: mem[a1]<=sum, last_wr<=sum.
  - RAM write lands 2 edges after the input edge. Back-to-back psums, including the same address every cycle, are accepted with no stall.
- Arithmetic: add in DATA_BITWIDTH+1 bits, then clamp to [-2**(DATA_BITWIDTH-1), 2**(DATA_BITWIDTH-1)-1]. Defaults clamp to -32768..32767.
- psum_enable_i in IDLE/DRAIN/DONE: data dropped, err<=1 (sticky until reset).
- Readback:
  - Serviced only in IDLE with no v1 pending. rd_req there gives rd_data<=mem[rd_addr] and rd_valid=1 on the next cycle.
  - rd_req in any other state: ignored, rd_valid=0 next cycle, no error.
  - rd_data holds its last value when rd_valid=0.
- busy = (state==ACCUM || state==DRAIN), registered with the state.

Decomposition:
- Shared package psum_glb_pkg: FSM state encoding (IDLE/ACCUM/DRAIN/DONE) and the saturation min/max constants derived from DATA_BITWIDTH.
- One natural sub-module: psum_ram, a 1R1W synchronous RAM (write port plus one read port, muxed between pipeline and readback by state).
- Saturating adder stays inline.

Test Plan:
- Overwrite then accumulate: first_pass=1, count=3, write 5,-2,7 to addr 0,1,2; then first_pass=0, same stream. Readback gives 10,-4,14; done pulses once per pass, 2 cycles after the last enable.
- Same-address back-to-back: accumulate pass, count=4, addr 9 every cycle with data 1,2,3,4 over mem[9]=0. Readback mem[9]=10, proving the forwarding path.
- Saturation: mem[3]=32000, accumulate +1000 gives 32767; mem[4]=-32000, accumulate -1000 gives -32768.
- Readback collision and err: rd_req during ACCUM gives rd_valid=0; a psum_enable_i in IDLE leaves the RAM unchanged and sets err=1, which stays set until reset.
- Zero-count and ignored start: start with psum_count=0 gives done the next cycle and busy never high. A second start during ACCUM does not restart the counter.
- Reset mid-pass: reset low one cycle after the 2nd of 4 enables. All outputs return to 0 and the FSM to IDLE; the first psum is committed and the second is not (check by readback).
